// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: frame-synchronous mode latch, colour-cycle counter, registered RGB.
// Define VGA_PATTERN_BARS_EN to compile in the vertical-bar (5) and checkerboard (6) modes.
module vga_pattern_gen #(
  parameter int COLOR_W   = 4,
  parameter int FRAME_DIV = 32,
  parameter int H_W       = 10,
  parameter int V_W       = 10,
  parameter int BAR_SHIFT = 6,
  parameter int SQ_SHIFT  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         mode,
  input  logic               frame_start,
  input  logic               onscreen,
  input  logic [H_W-1:0]     h_count,
  input  logic [V_W-1:0]     v_count,
  output logic [COLOR_W-1:0] r_out,
  output logic [COLOR_W-1:0] g_out,
  output logic [COLOR_W-1:0] b_out,
  output logic [2:0]         mode_active
);

  localparam int FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FC_W-1:0] FC_MAX = FC_W'(FRAME_DIV - 1);
  localparam logic [COLOR_W-1:0] ONES = {COLOR_W{1'b1}};

  logic [FC_W-1:0]    frame_cnt_reg, frame_cnt_next;
  logic [2:0]         color_idx_reg, color_idx_next;
  logic [2:0]         mode_active_reg, mode_active_next;
  logic [COLOR_W-1:0] r_reg, r_next, g_reg, g_next, b_reg, b_next;
  logic               frame_wrap;
  logic               unused_pins;

  // Bars/checker use only a few count bits; keep lint quiet about the rest.
  assign unused_pins = ^{h_count, v_count};

  assign frame_wrap = (frame_cnt_reg == FC_MAX);

  always_comb begin
    frame_cnt_next   = frame_cnt_reg;
    color_idx_next   = color_idx_reg;
    mode_active_next = mode_active_reg;
    if (frame_start) begin
      frame_cnt_next   = frame_wrap ? '0 : frame_cnt_reg + 1'b1;
      color_idx_next   = frame_wrap ? color_idx_reg + 3'd1 : color_idx_reg;
      mode_active_next = mode;
`ifndef VGA_PATTERN_BARS_EN
      // Modes without hardware behind them fall back to white.
      if (mode == 3'd5 || mode == 3'd6)
        mode_active_next = 3'd0;
`endif
    end
  end

  always_comb begin
    r_next = '0;
    g_next = '0;
    b_next = '0;
    if (onscreen) begin
      case (mode_active_reg)
        3'd1: begin
          r_next = {COLOR_W{color_idx_reg[0]}};
          g_next = {COLOR_W{color_idx_reg[1]}};
          b_next = {COLOR_W{color_idx_reg[2]}};
        end
        3'd2: r_next = ONES;
        3'd3: g_next = ONES;
        3'd4: b_next = ONES;
`ifdef VGA_PATTERN_BARS_EN
        3'd5: begin
          r_next = {COLOR_W{h_count[BAR_SHIFT]}};
          g_next = {COLOR_W{h_count[BAR_SHIFT+1]}};
          b_next = {COLOR_W{h_count[BAR_SHIFT+2]}};
        end
        3'd6: begin
          r_next = {COLOR_W{h_count[SQ_SHIFT] ^ v_count[SQ_SHIFT]}};
          g_next = r_next;
          b_next = r_next;
        end
`endif
        3'd7: begin
          r_next = h_count[H_W-1 -: COLOR_W];
          g_next = v_count[V_W-1 -: COLOR_W];
        end
        default: begin
          r_next = ONES;
          g_next = ONES;
          b_next = ONES;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_reg   <= '0;
      color_idx_reg   <= '0;
      mode_active_reg <= '0;
      r_reg           <= '0;
      g_reg           <= '0;
      b_reg           <= '0;
    end else begin
      frame_cnt_reg   <= frame_cnt_next;
      color_idx_reg   <= color_idx_next;
      mode_active_reg <= mode_active_next;
      r_reg           <= r_next;
      g_reg           <= g_next;
      b_reg           <= b_next;
    end
  end

  assign r_out       = r_reg;
  assign g_out       = g_reg;
  assign b_out       = b_reg;
  assign mode_active = mode_active_reg;

endmodule
